// File: rtl/spi_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// spi_cmd_sequencer
//
// Decodes the byte stream received by the SPI target into bus commands and
// runs one bus transaction per command. Read results are returned through
// spi_tx_data_o so the SPI target can shift them out on the next transfer.
//
// Command byte layout: cmd[7:5] opcode, cmd[4] busy-flag clear (reads only,
// optional feature), cmd[ADDR_WIDTH-17:0] upper address bits.
//   000 READ_AT    : cmd, addr_hi, addr_lo
//   001 READ_NEXT  : cmd
//   010 WRITE_AT   : cmd, data, addr_hi, addr_lo
//   011 WRITE_NEXT : cmd, data
//   others         : consumed, ignored
//
// Handshakes:
//   spi_valid_i is a one-cycle strobe; spi_data_i is captured on that edge.
//   bus_pending_o rises the cycle after the last frame byte and, together with
//   bus_addr_o / bus_data_o / bus_we_o, holds until bus_done_i is sampled high.
//   bus_done_i is a one-cycle strobe, ignored while nothing is pending.
//
// Optional feature macro: SPI_CMD_BUSY_ERR_EN
//   Defined  : busy_err_o is a sticky flag set when a byte arrives during a
//              bus transaction; cleared by reset or a read command with cmd[4]=1.
//   Undefined: busy_err_o is tied 0.
//
// Ports:
//   clock_i, reset_i       system clock, asynchronous active-high reset
//   spi_cs_ni              SPI chip select (async, synchronized here)
//   spi_data_i/spi_valid_i received byte and its strobe
//   spi_tx_data_o          byte for the next SPI transfer (last read result)
//   bus_addr_o/bus_data_o/bus_we_o/bus_pending_o  bus request
//   bus_data_i/bus_done_i  bus completion and read data
//   busy_err_o             sticky overrun flag
// -----------------------------------------------------------------------------
module spi_cmd_sequencer #(
   parameter int ADDR_WIDTH = 17
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  spi_cs_ni,
   input  logic [7:0]            spi_data_i,
   input  logic                  spi_valid_i,
   output logic [7:0]            spi_tx_data_o,
   output logic [ADDR_WIDTH-1:0] bus_addr_o,
   output logic [7:0]            bus_data_o,
   output logic                  bus_we_o,
   output logic                  bus_pending_o,
   input  logic [7:0]            bus_data_i,
   input  logic                  bus_done_i,
   output logic                  busy_err_o
);

   // Address bits taken from the command byte on top of the two address bytes.
   localparam int XB = ADDR_WIDTH - 16;

   typedef enum logic [2:0] {
      ST_CMD  = 3'd0,
      ST_ARG1 = 3'd1,
      ST_ARG2 = 3'd2,
      ST_ARG3 = 3'd3,
      ST_BUS  = 3'd4
   } state_t;

   localparam logic [2:0] OP_READ_AT    = 3'b000;
   localparam logic [2:0] OP_READ_NEXT  = 3'b001;
   localparam logic [2:0] OP_WRITE_AT   = 3'b010;
   localparam logic [2:0] OP_WRITE_NEXT = 3'b011;

   state_t                state_q, state_d;
   logic                  wr_q, wr_d;        // current frame is a write
   logic                  nxt_q, nxt_d;      // current frame uses the address register
   logic [XB-1:0]         ext_q, ext_d;      // upper address bits from cmd
   logic [7:0]            hi_q, hi_d;        // address high byte, held until frame completes
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            data_q, data_d;
   logic                  we_q, we_d;
   logic                  pend_q, pend_d;
   logic [7:0]            tx_q, tx_d;

   logic                  cs_meta_q, cs_sync_q, cs_prev_q;
   logic                  cs_rise;
   logic                  byte_ok;

   // Sync flops reset to "deselected" so leaving reset never fakes a CS edge.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         cs_meta_q <= 1'b1;
         cs_sync_q <= 1'b1;
         cs_prev_q <= 1'b1;
      end else begin
         cs_meta_q <= spi_cs_ni;
         cs_sync_q <= cs_meta_q;
         cs_prev_q <= cs_sync_q;
      end
   end

   assign cs_rise = cs_sync_q & ~cs_prev_q;
   // A byte arriving with the CS deassert edge belongs to an abandoned frame.
   assign byte_ok = spi_valid_i & ~cs_rise;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_CMD;
         wr_q    <= 1'b0;
         nxt_q   <= 1'b0;
         ext_q   <= '0;
         hi_q    <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         pend_q  <= 1'b0;
         tx_q    <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         nxt_q   <= nxt_d;
         ext_q   <= ext_d;
         hi_q    <= hi_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         we_q    <= we_d;
         pend_q  <= pend_d;
         tx_q    <= tx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      nxt_d   = nxt_q;
      ext_d   = ext_q;
      hi_d    = hi_q;
      addr_d  = addr_q;
      data_d  = data_q;
      we_d    = we_q;
      pend_d  = pend_q;
      tx_d    = tx_q;

      case (state_q)
         ST_CMD: begin
            if (byte_ok) begin
               wr_d  = spi_data_i[6];
               nxt_d = spi_data_i[5];
               ext_d = spi_data_i[XB-1:0];
               case (spi_data_i[7:5])
                  OP_READ_AT, OP_WRITE_AT, OP_WRITE_NEXT: state_d = ST_ARG1;
                  OP_READ_NEXT: begin
                     we_d    = 1'b0;
                     pend_d  = 1'b1;
                     state_d = ST_BUS;
                  end
                  default: state_d = ST_CMD;
               endcase
            end
         end

         ST_ARG1: begin
            if (cs_rise) begin
               state_d = ST_CMD;
            end else if (spi_valid_i) begin
               if (wr_q) begin
                  data_d = spi_data_i;
                  if (nxt_q) begin
                     we_d    = 1'b1;
                     pend_d  = 1'b1;
                     state_d = ST_BUS;
                  end else begin
                     state_d = ST_ARG2;
                  end
               end else begin
                  hi_d    = spi_data_i;
                  state_d = ST_ARG2;
               end
            end
         end

         ST_ARG2: begin
            if (cs_rise) begin
               state_d = ST_CMD;
            end else if (spi_valid_i) begin
               if (wr_q) begin
                  hi_d    = spi_data_i;
                  state_d = ST_ARG3;
               end else begin
                  addr_d  = {ext_q, hi_q, spi_data_i};
                  we_d    = 1'b0;
                  pend_d  = 1'b1;
                  state_d = ST_BUS;
               end
            end
         end

         ST_ARG3: begin
            if (cs_rise) begin
               state_d = ST_CMD;
            end else if (spi_valid_i) begin
               addr_d  = {ext_q, hi_q, spi_data_i};
               we_d    = 1'b1;
               pend_d  = 1'b1;
               state_d = ST_BUS;
            end
         end

         // CS deassert is deliberately not looked at here: an issued
         // transaction always runs to completion. Incoming bytes are dropped.
         ST_BUS: begin
            if (bus_done_i) begin
               pend_d = 1'b0;
               if (!we_q) tx_d = bus_data_i;
               addr_d  = addr_q + ADDR_WIDTH'(1);
               state_d = ST_CMD;
            end
         end

         default: state_d = ST_CMD;
      endcase
   end

`ifdef SPI_CMD_BUSY_ERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (state_q == ST_BUS && byte_ok) begin
         err_d = 1'b1;
      end else if (state_q == ST_CMD && byte_ok &&
                   spi_data_i[7:6] == 2'b00 && spi_data_i[4]) begin
         // Read command (opcode 000/001) with the clear bit set.
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) err_q <= 1'b0;
      else         err_q <= err_d;
   end

   assign busy_err_o = err_q;
`else
   assign busy_err_o = 1'b0;
`endif

   assign spi_tx_data_o = tx_q;
   assign bus_addr_o    = addr_q;
   assign bus_data_o    = data_q;
   assign bus_we_o      = we_q;
   assign bus_pending_o = pend_q;

endmodule
